// File: rtl/dmem_responder.sv
// Data-memory target for an RV32I core: valid/ready request, programmable wait states,
// sized/extended load-store access with misalignment, range and funct3 error reporting.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {StIdle, StWait, StAccess, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic [1:0]    off;
    logic [AW-1:0] idx;
    logic          out_of_range;
    logic          bad_funct3;
    logic          misaligned;
    logic          legal;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   ld_data;
    logic [3:0]    be;
    logic [31:0]   st_data;
    logic          wr_en;

    // Access decode works on the latched request only.
    always_comb begin
        off          = addr_q[1:0];
        idx          = addr_q[AW+1:2];
        out_of_range = ({2'b00, addr_q[31:2]} >= DEPTH_WORDS);
        bad_funct3   = funct3_q[2] && (we_q || funct3_q[1]);
        misaligned   = 1'b0;
        be           = 4'b1111;
        case (funct3_q[1:0])
            2'b00: be = 4'b0001 << off;
            2'b01: begin
                misaligned = off[0];
                be         = 4'b0011 << off;
            end
            2'b10: misaligned = (off != 2'b00);
            default: bad_funct3 = 1'b1;
        endcase
        legal   = !(bad_funct3 || misaligned || out_of_range);
        rd_word = mem[idx];
        rd_byte = rd_word[{off, 3'b000} +: 8];
        rd_half = rd_word[{off[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
            3'b100:  ld_data = {24'h0, rd_byte};
            3'b101:  ld_data = {16'h0, rd_half};
            default: ld_data = rd_word;
        endcase
        st_data = wdata_q << {off, 3'b000};
        wr_en   = (state_q == StAccess) && we_q && legal;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Storage is deliberately not reset; an async reset moves state_q out of
    // StAccess, so a pending store can never commit.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en && be[i]) begin
                mem[idx][8*i +: 8] <= st_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    if (WAIT_CYCLES != 0) begin
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                        state_d = StWait;
                    end else begin
                        state_d = StAccess;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StAccess;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAccess: begin
                rdata_d = (legal && !we_q) ? ld_data : 32'd0;
                err_d   = !legal;
                state_d = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            StIdle:  req_ready = 1'b1;
            StResp:  rsp_valid = 1'b1;
            default: ;
        endcase
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
    end

endmodule
